// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between the link, load and ALU
// writeback sources. Fixed priority (link > load > ALU), backed by per-source
// starvation counters. The winning write is registered onto the port.
// Optional feature macro: REGARB_ZERO_DISCARD_EN. When it is defined, granted
// writes to index 0 complete the handshake but never reach the port.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [2:0]          Req,
    input  logic [3*ADDR_W-1:0] Addr,
    input  logic [3*DATA_W-1:0] Data,
    output logic [2:0]          Gnt,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   WriteReg,
    output logic [DATA_W-1:0]   WriteData,
    output logic                Stall
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [2:0][3:0]    waitCnt;
    logic [2:0]         starved;
    logic [ADDR_W-1:0]  gntAddr;
    logic [DATA_W-1:0]  gntData;
    logic               gntWrite;

    // Flag requesters that have waited the full limit and are still asking.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            starved[i] = Req[i] && (waitCnt[i] == Limit);
        end
    end

    // Pick one winner: the lowest starved index first, otherwise the lowest requester.
    // Gnt and Stall are held low while reset is asserted.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        Gnt = 3'b000;
        if (Reset_n) begin
            if      (starved[0]) Gnt = 3'b001;
            else if (starved[1]) Gnt = 3'b010;
            else if (starved[2]) Gnt = 3'b100;
            else if (Req[0])     Gnt = 3'b001;
            else if (Req[1])     Gnt = 3'b010;
            else if (Req[2])     Gnt = 3'b100;
        end
        Stall = Reset_n && ((Req & ~Gnt) != 3'b000);
    end

    // Route the granted requester's payload towards the port register.
    always_comb begin
        gntAddr = '0;
        gntData = '0;
        for (int i = 0; i < 3; i++) begin
            if (Gnt[i]) begin
                gntAddr = Addr[i*ADDR_W +: ADDR_W];
                gntData = Data[i*DATA_W +: DATA_W];
            end
        end
`ifdef REGARB_ZERO_DISCARD_EN
        // Register 0 is hard-wired, so a write to it is accepted and then dropped.
        gntWrite = (Gnt != 3'b000) && (gntAddr != '0);
`else
        gntWrite = (Gnt != 3'b000);
`endif
    end

    // Count consecutive denied cycles per requester, saturating at the limit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            waitCnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
                if (Req[i] && !Gnt[i]) begin
                    waitCnt[i] <= (waitCnt[i] == Limit) ? Limit : waitCnt[i] + 4'd1;
                end else begin
                    waitCnt[i] <= 4'd0;
                end
            end
        end
    end

    // Register the port. Index and data hold their values when nothing is written.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= gntWrite;
            if (gntWrite) begin
                WriteReg  <= gntAddr;
                WriteData <= gntData;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// The bench runs directed scenarios with literal expectations, then randomized traffic.
// A behavioural model checks every cycle. Define REGARB_ZERO_DISCARD_EN for both
// the RTL and the bench to cover the zero-discard build.
module tb_regfile_write_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LIM = 4;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [2:0]    Req = 3'b000;
    logic [3*AW-1:0] Addr = '0;
    logic [3*DW-1:0] Data = '0;
    logic [2:0]    Gnt;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic          Stall;

    int errors = 0;
    int checks = 0;

    // Register file contents as the DUT's port actually writes them.
    logic [DW-1:0] dutRf [32];

    // Behavioural model state: wait counts and the expected port contents.
    int            mCnt [3];
    logic          mRegWrite;
    logic [AW-1:0] mWriteReg;
    logic [DW-1:0] mWriteData;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Req       (Req),
        .Addr      (Addr),
        .Data      (Data),
        .Gnt       (Gnt),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .Stall     (Stall)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (RegWrite) dutRf[WriteReg] <= WriteData;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model. The model then advances to the
    // state it must hold after the coming rising edge.
    always @(negedge Clk) begin : compare
        int            g;
        logic [2:0]    expGnt;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!Reset_n) begin
            for (int i = 0; i < 3; i++) mCnt[i] = 0;
            mRegWrite  = 1'b0;
            mWriteReg  = '0;
            mWriteData = '0;
            check("rst_gnt", 64'(Gnt), 64'd0);
            check("rst_stall", 64'(Stall), 64'd0);
            check("rst_regwrite", 64'(RegWrite), 64'd0);
            check("rst_writereg", 64'(WriteReg), 64'd0);
            check("rst_writedata", 64'(WriteData), 64'd0);
        end else begin
            check("m_regwrite", 64'(RegWrite), 64'(mRegWrite));
            check("m_writereg", 64'(WriteReg), 64'(mWriteReg));
            check("m_writedata", 64'(WriteData), 64'(mWriteData));
            g = -1;
            for (int i = 0; i < 3; i++) if (g < 0 && Req[i] && mCnt[i] == LIM) g = i;
            for (int i = 0; i < 3; i++) if (g < 0 && Req[i]) g = i;
            expGnt = (g < 0) ? 3'b000 : 3'(1 << g);
            check("m_gnt", 64'(Gnt), 64'(expGnt));
            check("m_stall", 64'(Stall), 64'((Req & ~expGnt) != 3'b000));
            for (int i = 0; i < 3; i++) begin
                if (Req[i] && i != g) mCnt[i] = (mCnt[i] + 1 > LIM) ? LIM : mCnt[i] + 1;
                else                  mCnt[i] = 0;
            end
            if (g >= 0) begin
                a = Addr[g*AW +: AW];
                d = Data[g*DW +: DW];
`ifdef REGARB_ZERO_DISCARD_EN
                if (a == '0) begin
                    mRegWrite = 1'b0;
                end else begin
                    mRegWrite = 1'b1; mWriteReg = a; mWriteData = d;
                end
`else
                mRegWrite = 1'b1; mWriteReg = a; mWriteData = d;
`endif
            end else begin
                mRegWrite = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        Addr[i*AW +: AW] = a;
        Data[i*DW +: DW] = d;
    endtask

    initial begin
        // Reset held with every requester asking.
        Req = 3'b111;
        @(negedge Clk);
        check("reset_gnt", 64'(Gnt), 64'd0);
        check("reset_stall", 64'(Stall), 64'd0);
        check("reset_regwrite", 64'(RegWrite), 64'd0);
        tick(); Reset_n = 1'b1;
        @(negedge Clk);
        check("release_gnt", 64'(Gnt), 64'b001);
        tick(); Req = 3'b000;
        tick();

        // Single ALU write.
        put(2, 5'd5, 32'hDEADBEEF); Req = 3'b100;
        @(negedge Clk);
        check("single_gnt", 64'(Gnt), 64'b100);
        check("single_stall", 64'(Stall), 64'd0);
        tick(); Req = 3'b000;
        @(negedge Clk);
        check("single_we", 64'(RegWrite), 64'd1);
        check("single_reg", 64'(WriteReg), 64'd5);
        check("single_data", 64'(WriteData), 64'hDEADBEEF);
        tick();
        @(negedge Clk);
        check("single_we_off", 64'(RegWrite), 64'd0);

        // Fixed priority, each requester drops after its grant.
        put(0, 5'd31, 32'd8); put(1, 5'd2, 32'd7); put(2, 5'd3, 32'd9); Req = 3'b111;
        @(negedge Clk);
        check("prio_gnt0", 64'(Gnt), 64'b001);
        tick(); Req = 3'b110;
        @(negedge Clk);
        check("prio_gnt1", 64'(Gnt), 64'b010);
        check("prio_port0", 64'({WriteReg, WriteData}), 64'({5'd31, 32'd8}));
        tick(); Req = 3'b100;
        @(negedge Clk);
        check("prio_gnt2", 64'(Gnt), 64'b100);
        check("prio_port1", 64'({WriteReg, WriteData}), 64'({5'd2, 32'd7}));
        tick(); Req = 3'b000;
        @(negedge Clk);
        check("prio_port2", 64'({RegWrite, WriteReg, WriteData}), 64'({1'b1, 5'd3, 32'd9}));
        tick();

        // Starvation: link asks every cycle, ALU waits LIM cycles and then wins.
        put(0, 5'd10, 32'd100); put(2, 5'd11, 32'd200); Req = 3'b101;
        for (int k = 0; k < LIM; k++) begin
            @(negedge Clk);
            check("starve_denied", 64'(Gnt), 64'b001);
            check("starve_stall", 64'(Stall), 64'd1);
            tick();
        end
        @(negedge Clk);
        check("starve_granted", 64'(Gnt), 64'b100);
        check("starve_stall_win", 64'(Stall), 64'd1);
        tick();
        @(negedge Clk);
        check("starve_cleared", 64'(Gnt), 64'b001);
        tick(); Req = 3'b000;
        tick();

        // Same destination from load and ALU: later grant wins.
        put(1, 5'd7, 32'd1); put(2, 5'd7, 32'd2); Req = 3'b110;
        @(negedge Clk);
        check("coll_gnt0", 64'(Gnt), 64'b010);
        tick(); Req = 3'b100;
        @(negedge Clk);
        check("coll_port0", 64'({WriteReg, WriteData}), 64'({5'd7, 32'd1}));
        tick(); Req = 3'b000;
        @(negedge Clk);
        check("coll_port1", 64'({WriteReg, WriteData}), 64'({5'd7, 32'd2}));
        tick();
        @(negedge Clk);
        check("coll_rf7", 64'(dutRf[7]), 64'd2);

        // Load write to index 0.
        put(1, 5'd0, 32'd5); Req = 3'b010;
        @(negedge Clk);
        check("zero_gnt", 64'(Gnt), 64'b010);
        tick(); Req = 3'b000;
        @(negedge Clk);
`ifdef REGARB_ZERO_DISCARD_EN
        check("zero_we", 64'(RegWrite), 64'd0);
`else
        check("zero_port", 64'({RegWrite, WriteReg, WriteData}), 64'({1'b1, 5'd0, 32'd5}));
`endif
        tick();

        // Reset mid-operation discards the captured write.
        put(0, 5'd4, 32'd44); Req = 3'b111;
        @(negedge Clk);
        check("midrst_gnt_pre", 64'(Gnt), 64'b001);
        tick(); Reset_n = 1'b0;
        @(negedge Clk);
        check("midrst_we", 64'(RegWrite), 64'd0);
        check("midrst_gnt", 64'(Gnt), 64'd0);
        tick(); Reset_n = 1'b1; Req = 3'b000;
        tick();

        // Randomized traffic with heavy request load and rare reset pulses.
        for (int n = 0; n < 600; n++) begin
            tick();
            Reset_n = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < 3; i++) begin
                Req[i] = ($urandom_range(0, 9) < 8);
                put(i, AW'($urandom_range(0, 3)), $urandom);
            end
        end
        tick(); Reset_n = 1'b1; Req = 3'b000;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
